// File: rtl/recovery_ckpt_ctrl.sv
// Recovery checkpoint sequencer: copies the architectural regfile into the
// recovery file (save) and back (restore), one entry per cycle, stalling the core.
module recovery_ckpt_ctrl #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned SKIP_X0  = 1
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic              ckpt_req,
  input  logic              rollback_req,
  output logic              busy,
  output logic              stall_o,
  output logic              done,
  output logic              ckpt_valid,
  output logic              rollback_err,
  output logic [ADDR_W-1:0] rf_ra,
  input  logic [DATA_W-1:0] rf_rd,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic              rr_we,
  output logic [31:0]       rr_addr,
  output logic [DATA_W-1:0] rr_wd,
  input  logic [DATA_W-1:0] rr_rd
);

  localparam logic [ADDR_W-1:0] FIRST = (SKIP_X0 != 0) ? ADDR_W'(1) : ADDR_W'(0);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {IDLE, SAVE, RESTORE, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;

  // Sequencer: state, index, checkpoint status and error pulse
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state        <= IDLE;
      idx          <= FIRST;
      ckpt_valid   <= 1'b0;
      rollback_err <= 1'b0;
    end else begin
      rollback_err <= 1'b0;
      case (state)
        IDLE: begin
          idx <= FIRST;
          if (rollback_req) begin
            if (ckpt_valid) state <= RESTORE;
            else            rollback_err <= 1'b1;
          end else if (ckpt_req) begin
            state      <= SAVE;
            ckpt_valid <= 1'b0;
          end
        end
        SAVE: begin
          // A rollback during a save abandons the half-written checkpoint
          if (rollback_req) begin
            state        <= IDLE;
            idx          <= FIRST;
            rollback_err <= 1'b1;
          end else if (idx == LAST) begin
            state      <= DONE;
            ckpt_valid <= 1'b1;
          end else begin
            idx <= idx + ADDR_W'(1);
          end
        end
        RESTORE: begin
          if (idx == LAST) state <= DONE;
          else             idx   <= idx + ADDR_W'(1);
        end
        DONE: begin
          state <= IDLE;
          idx   <= FIRST;
        end
        default: begin
          state <= IDLE;
          idx   <= FIRST;
        end
      endcase
    end
  end

  // Copy datapath decoded from the registered state and index
  always_comb begin
    busy    = (state != IDLE);
    stall_o = busy;
    done    = (state == DONE);
    rf_ra   = '0;
    rf_we   = 1'b0;
    rf_wa   = '0;
    rf_wd   = '0;
    rr_we   = 1'b0;
    rr_addr = '0;
    rr_wd   = '0;
    case (state)
      SAVE: begin
        rf_ra   = idx;
        rr_addr = 32'(idx);
        rr_wd   = rf_rd;
        rr_we   = ~rollback_req;
      end
      RESTORE: begin
        rr_addr = 32'(idx);
        rf_wa   = idx;
        rf_wd   = rr_rd;
        rf_we   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_recovery_ckpt_ctrl.sv
// Directed bench for recovery_ckpt_ctrl with behavioural main and recovery regfiles.
module tb_recovery_ckpt_ctrl;

  logic        clk = 1'b0;
  logic        rst_in, ckpt_req, rollback_req;
  logic        busy, stall_o, done, ckpt_valid, rollback_err;
  logic [4:0]  rf_ra, rf_wa;
  logic [31:0] rf_rd, rf_wd, rr_wd, rr_rd, rr_addr;
  logic        rf_we, rr_we;

  logic [31:0] rf_mem [32];
  logic [31:0] rr_mem [32];
  logic        tb_we;
  logic [4:0]  tb_wa;
  logic [31:0] tb_wd;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  recovery_ckpt_ctrl dut (
    .clk(clk), .rst_in(rst_in), .ckpt_req(ckpt_req), .rollback_req(rollback_req),
    .busy(busy), .stall_o(stall_o), .done(done), .ckpt_valid(ckpt_valid),
    .rollback_err(rollback_err), .rf_ra(rf_ra), .rf_rd(rf_rd), .rf_we(rf_we),
    .rf_wa(rf_wa), .rf_wd(rf_wd), .rr_we(rr_we), .rr_addr(rr_addr),
    .rr_wd(rr_wd), .rr_rd(rr_rd)
  );

  assign rf_rd = rf_mem[rf_ra];
  assign rr_rd = rr_mem[rr_addr[4:0]];

  always @(posedge clk) begin
    if (tb_we) rf_mem[tb_wa] <= tb_wd;
    else if (rf_we) rf_mem[rf_wa] <= rf_wd;
    if (rr_we) rr_mem[rr_addr[4:0]] <= rr_wd;
  end

  function automatic logic [31:0] init_val(input int k);
    return (k == 5) ? 32'hDEAD_BEEF : 32'h1000_0000 + 32'(k);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {busy, stall_o, done, ckpt_valid, rollback_err, rf_we, rr_we}
  function automatic logic [6:0] flags();
    return {busy, stall_o, done, ckpt_valid, rollback_err, rf_we, rr_we};
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf_mem[i] = init_val(i);
      rr_mem[i] = 32'h0;
    end
    tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
    rst_in = 1'b1; ckpt_req = 1'b0; rollback_req = 1'b0;
    tick(); tick();
    rst_in = 1'b0;

    // Reset state
    chk("reset_flags", 64'(flags()), 64'(7'b0000000));
    chk("reset_addr", {27'b0, rf_ra, rr_addr}, 64'h0);
    chk("reset_data", {rf_wd, rr_wd}, 64'h0);

    // Rollback without a checkpoint is refused
    rollback_req = 1'b1;
    tick();
    rollback_req = 1'b0;
    chk("noval_err", 64'(flags()), 64'(7'b0000100));
    tick();
    chk("noval_err_clr", 64'(flags()), 64'(7'b0000000));

    // Full save: 31 writes at 1..31, done on the 32nd cycle
    ckpt_req = 1'b1;
    tick();
    ckpt_req = 1'b0;
    for (int k = 1; k < 32; k++) begin
      chk($sformatf("save_%0d", k), {7'(flags()), 5'(rr_addr), rr_wd},
          {7'b1100001, 5'(k), init_val(k)});
      tick();
    end
    chk("save_done", 64'(flags()), 64'(7'b1111000));
    tick();
    chk("save_idle", 64'(flags()), 64'(7'b0001000));
    chk("rr_x5", 64'(rr_mem[5]), 64'(32'hDEAD_BEEF));
    chk("rr_x0_untouched", 64'(rr_mem[0]), 64'h0);

    // Clobber x5 then roll back
    tb_we = 1'b1; tb_wa = 5'd5; tb_wd = 32'h0;
    tick();
    tb_we = 1'b0;
    chk("x5_clobbered", 64'(rf_mem[5]), 64'h0);
    rollback_req = 1'b1;
    tick();
    rollback_req = 1'b0;
    for (int k = 1; k < 32; k++) begin
      chk($sformatf("restore_%0d", k), {7'(flags()), 5'(rf_wa), rf_wd},
          {7'b1101010, 5'(k), init_val(k)});
      tick();
    end
    chk("restore_done", 64'(flags()), 64'(7'b1111000));
    tick();
    chk("x5_restored", 64'(rf_mem[5]), 64'(32'hDEAD_BEEF));
    chk("restore_idle", 64'(flags()), 64'(7'b0001000));

    // Simultaneous requests: rollback wins
    ckpt_req = 1'b1; rollback_req = 1'b1;
    tick();
    ckpt_req = 1'b0; rollback_req = 1'b0;
    for (int k = 1; k < 32; k++) begin
      chk($sformatf("both_%0d", k), {7'(flags()), 5'(rf_wa)}, {7'b1101010, 5'(k)});
      tick();
    end
    chk("both_done", 64'(flags()), 64'(7'b1111000));
    tick();

    // Rollback during the 10th save cycle aborts the save
    ckpt_req = 1'b1;
    tick();
    ckpt_req = 1'b0;
    for (int k = 1; k < 10; k++) begin
      chk($sformatf("psave_%0d", k), {7'(flags()), 5'(rr_addr)}, {7'b1100001, 5'(k)});
      tick();
    end
    rollback_req = 1'b1;
    #1;
    chk("abort_nowrite", {7'(flags()), 5'(rr_addr)}, {7'b1100000, 5'd10});
    tick();
    rollback_req = 1'b0;
    chk("abort_err", 64'(flags()), 64'(7'b0000100));
    tick();
    chk("abort_idle", 64'(flags()), 64'(7'b0000000));
    chk("abort_rr10_kept", 64'(rr_mem[10]), 64'(init_val(10)));

    // New checkpoint, then reset in the middle of the restore at idx 12
    ckpt_req = 1'b1;
    tick();
    ckpt_req = 1'b0;
    for (int k = 1; k < 32; k++) tick();
    chk("ckpt2_done", 64'(flags()), 64'(7'b1111000));
    tick();
    rollback_req = 1'b1;
    tick();
    rollback_req = 1'b0;
    for (int k = 1; k < 12; k++) tick();
    chk("pre_rst_idx12", {7'(flags()), 5'(rf_wa)}, {7'b1101010, 5'd12});
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    chk("midrst_flags", 64'(flags()), 64'(7'b0000000));
    chk("midrst_addr", {27'b0, rf_ra, rr_addr}, 64'h0);
    chk("midrst_wa", {27'b0, rf_wa}, 64'h0);
    rollback_req = 1'b1;
    tick();
    rollback_req = 1'b0;
    chk("midrst_noval", 64'(flags()), 64'(7'b0000100));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
